// File: rtl/div_seq_if.sv
// Handshake and data bundle between the execute-stage pipeline and the divide sequencer.
interface div_seq_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic                 signed_div;
  logic                 annul;
  logic [WIDTH-1:0]     opdata1;
  logic [WIDTH-1:0]     opdata2;
  logic                 busy;
  logic                 ready;
  logic [2*WIDTH-1:0]   result;

  modport master (
    output start, signed_div, annul, opdata1, opdata2,
    input  busy, ready, result
  );

  modport slave (
    input  start, signed_div, annul, opdata1, opdata2,
    output busy, ready, result
  );
endinterface

// File: rtl/div_seq_ctrl.sv
// Radix-2 restoring divider sequencer for DIV/DIVU: one quotient bit per cycle,
// stalls the pipeline while busy and presents {remainder, quotient} for HI/LO.
module div_seq_ctrl #(
  parameter int WIDTH = 32
) (
  input  logic       clk,
  input  logic       resetn,
  div_seq_if.slave   bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_DIVZ, S_ON, S_END} state_t;

  state_t               state_q;
  logic [CW-1:0]        cnt_q;
  logic [WIDTH-1:0]     dvd_q;
  logic [WIDTH-1:0]     dsr_q;
  logic [WIDTH-1:0]     rem_q;
  logic [WIDTH-1:0]     quo_q;
  logic                 qsign_q;
  logic                 rsign_q;
  logic                 ready_q;
  logic [2*WIDTH-1:0]   result_q;

  logic                 a_neg, b_neg;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       partial, diff;
  logic                 q_bit;
  logic [WIDTH-1:0]     rem_d, quo_d;

  assign a_neg = bus.signed_div & bus.opdata1[WIDTH-1];
  assign b_neg = bus.signed_div & bus.opdata2[WIDTH-1];
  assign a_mag = a_neg ? (~bus.opdata1 + 1'b1) : bus.opdata1;
  assign b_mag = b_neg ? (~bus.opdata2 + 1'b1) : bus.opdata2;

  // Partial remainder is always below the divisor, so bit WIDTH of the
  // WIDTH+1-bit difference is a reliable borrow/sign indicator.
  assign partial = {rem_q, dvd_q[WIDTH-1]};
  assign diff    = partial - {1'b0, dsr_q};
  assign q_bit   = ~diff[WIDTH];
  assign rem_d   = q_bit ? diff[WIDTH-1:0] : partial[WIDTH-1:0];
  assign quo_d   = {quo_q[WIDTH-2:0], q_bit};

  assign bus.busy   = (state_q == S_IDLE && bus.start && !bus.annul) ||
                      (state_q == S_ON) || (state_q == S_DIVZ);
  assign bus.ready  = ready_q;
  assign bus.result = result_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      dvd_q    <= '0;
      dsr_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      qsign_q  <= 1'b0;
      rsign_q  <= 1'b0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.start && !bus.annul) begin
            dvd_q   <= a_mag;
            dsr_q   <= b_mag;
            rem_q   <= '0;
            quo_q   <= '0;
            qsign_q <= a_neg ^ b_neg;
            rsign_q <= a_neg;
            cnt_q   <= '0;
            state_q <= (bus.opdata2 == '0) ? S_DIVZ : S_ON;
          end
        end
        S_ON: begin
          if (bus.annul) begin
            state_q <= S_IDLE;
          end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              result_q <= {rsign_q ? (~rem_d + 1'b1) : rem_d,
                           qsign_q ? (~quo_d + 1'b1) : quo_d};
              ready_q  <= 1'b1;
              state_q  <= S_END;
            end
          end
        end
        S_DIVZ: begin
          if (bus.annul) begin
            state_q <= S_IDLE;
          end else begin
            result_q <= '0;
            ready_q  <= 1'b1;
            state_q  <= S_END;
          end
        end
        S_END: begin
          if (!bus.start || bus.annul) begin
            ready_q <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div_seq_ctrl.sv
// Randomized scoreboard bench for div_seq_ctrl against an arithmetic reference model.
module tb_div_seq_ctrl;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  div_seq_if #(.WIDTH(32)) bus();

  div_seq_ctrl #(.WIDTH(32)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic        prev_ready = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit integer division; C-style truncation matches DIV/DIVU.
  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
    longint sa, sb, q, r;
    if (b == 32'd0) return 64'd0;
    if (sg) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q = sa / sb;
    r = sa % sb;
    return {r[31:0], q[31:0]};
  endfunction

  // Monitor: compare on every rising edge of ready.
  always @(negedge clk) begin
    if (bus.ready && !prev_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result 0x%0h expected no result", bus.result);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        check("result", bus.result, e);
        $display("txn result=0x%016h expected=0x%016h", bus.result, e);
      end
    end
    prev_ready <= bus.ready;
  end

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sg);
    int lat;
    int exp_lat;
    int hold;
    logic busy_ok;
    logic [63:0] snap;
    exp_lat = (b == 32'd0) ? 2 : 33;
    @(negedge clk);
    bus.opdata1 = a;
    bus.opdata2 = b;
    bus.signed_div = sg;
    bus.annul = 1'b0;
    bus.start = 1'b1;
    exp_q.push_back(model(a, b, sg));
    #1 check("busy_cycle0", 64'(bus.busy), 64'd1);
    lat = -1;
    busy_ok = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (k == 1) begin
        bus.opdata1 = $urandom;
        bus.opdata2 = $urandom;
        bus.signed_div = ~sg;
      end
      if (bus.ready) begin
        lat = k;
        break;
      end
      if (!bus.busy) busy_ok = 1'b0;
    end
    check("latency", 64'(lat), 64'(exp_lat));
    check("busy_while_running", 64'(busy_ok), 64'd1);
    check("busy_low_in_end", 64'(bus.busy), 64'd0);
    snap = bus.result;
    hold = $urandom_range(0, 3);
    for (int k = 0; k < hold; k++) @(negedge clk);
    check("result_stable", bus.result, snap);
    bus.start = 1'b0;
    @(negedge clk);
    check("ready_drop", 64'(bus.ready), 64'd0);
    check("result_kept", bus.result, snap);
    $display("txn op=%s a=0x%08h b=0x%08h lat=%0d", sg ? "DIV" : "DIVU", a, b, lat);
  endtask

  initial begin
    logic [31:0] specials[6];
    logic [31:0] a, b;
    specials = '{32'h0, 32'h1, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    bus.start = 1'b0;
    bus.annul = 1'b0;
    bus.signed_div = 1'b0;
    bus.opdata1 = '0;
    bus.opdata2 = '0;
    repeat (2) @(negedge clk);
    check("reset_ready", 64'(bus.ready), 64'd0);
    check("reset_result", bus.result, 64'd0);
    check("reset_busy", 64'(bus.busy), 64'd0);
    resetn = 1'b1;

    run_op(32'd7, 32'd2, 1'b0);
    run_op(32'hFFFFFFF9, 32'd2, 1'b1);
    run_op(32'd7, 32'hFFFFFFFE, 1'b1);
    run_op(32'hFFFFFFFF, 32'd0, 1'b0);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b1);
    run_op(32'h80000000, 32'hFFFFFFFF, 1'b0);

    // Annul in flight at cycle 10.
    @(negedge clk);
    bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    for (int k = 1; k <= 10; k++) @(negedge clk);
    bus.annul = 1'b1;
    @(negedge clk);
    check("annul_busy_low", 64'(bus.busy), 64'd0);
    bus.start = 1'b0;
    bus.annul = 1'b0;
    @(negedge clk);
    check("annul_busy_low_idle", 64'(bus.busy), 64'd0);
    repeat (40) @(negedge clk);
    $display("txn annul op=DIVU a=100 b=7");

    // Asynchronous reset mid-operation at cycle 15.
    @(negedge clk);
    bus.opdata1 = 32'd100; bus.opdata2 = 32'd7; bus.signed_div = 1'b0; bus.start = 1'b1;
    for (int k = 1; k <= 15; k++) @(negedge clk);
    resetn = 1'b0;
    #1;
    check("midreset_ready", 64'(bus.ready), 64'd0);
    check("midreset_result", bus.result, 64'd0);
    bus.start = 1'b0;
    #1 check("midreset_idle_busy", 64'(bus.busy), 64'd0);
    @(negedge clk);
    resetn = 1'b1;
    repeat (40) @(negedge clk);
    $display("txn reset mid-op op=DIVU a=100 b=7");
    run_op(32'd100, 32'd7, 1'b0);

    for (int i = 0; i < 30; i++) begin
      a = ($urandom_range(0, 3) == 0) ? specials[$urandom_range(0, 5)] : $urandom;
      case ($urandom_range(0, 4))
        0: b = specials[$urandom_range(0, 5)];
        1: b = $urandom_range(1, 15);
        2: b = 32'(-$urandom_range(1, 15));
        default: b = $urandom;
      endcase
      run_op(a, b, 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
